// File: rtl/eviction_write_buffer_pkg.sv
// Shared address width and line-address helper for the eviction write buffer.
package eviction_write_buffer_pkg;

    localparam int unsigned ADDR_W = 32;

    // Clears the byte-offset bits so two addresses can be compared at line granularity.
    function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] addr,
                                                    input int unsigned        offset);
        logic [ADDR_W-1:0] mask;
        mask = (32'd1 << offset) - 32'd1;
        return addr & ~mask;
    endfunction

endpackage

// File: rtl/eviction_write_buffer.sv
// Single-entry write-back buffer between the D-cache memory side and the arbiter D-port.
// Evicted dirty lines are parked here so line fills can bypass the write-back.
module eviction_write_buffer
    import eviction_write_buffer_pkg::*;
#(
    parameter int unsigned s_offset = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [31:0]                  c_address,
    input  logic [(8 << s_offset)-1:0]   c_wdata,
    input  logic                         c_read,
    input  logic                         c_write,
    output logic [(8 << s_offset)-1:0]   c_rdata,
    output logic                         c_resp,
    output logic [31:0]                  m_address,
    output logic [(8 << s_offset)-1:0]   m_wdata,
    output logic                         m_read,
    output logic                         m_write,
    input  logic [(8 << s_offset)-1:0]   m_rdata,
    input  logic                         m_resp
);

    localparam int unsigned W = 8 << s_offset;

    typedef enum logic [1:0] {StIdle, StAck, StMemRead, StMemWrite} state_e;

    state_e         state_q, state_d;
    logic           valid_q, valid_d;
    logic [31:0]    addr_q, addr_d;
    logic [W-1:0]   data_q, data_d;
    logic [W-1:0]   rdata_q, rdata_d;
    logic           hit;

    assign hit = valid_q && (line_base(c_address, s_offset) == line_base(addr_q, s_offset));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        addr_d    = addr_q;
        data_d    = data_q;
        rdata_d   = rdata_q;
        c_resp    = 1'b0;
        c_rdata   = rdata_q;
        m_address = '0;
        m_wdata   = '0;
        m_read    = 1'b0;
        m_write   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (c_write) begin
                    // A write to a different line must drain the old entry first.
                    if (!valid_q || hit) begin
                        valid_d = 1'b1;
                        addr_d  = c_address;
                        data_d  = c_wdata;
                        state_d = StAck;
                    end else begin
                        state_d = StMemWrite;
                    end
                end else if (c_read) begin
                    if (hit) begin
                        rdata_d = data_q;
                        state_d = StAck;
                    end else begin
                        state_d = StMemRead;
                    end
                end else if (valid_q) begin
                    state_d = StMemWrite;
                end
            end
            StAck: begin
                c_resp  = 1'b1;
                state_d = StIdle;
            end
            StMemRead: begin
                m_read    = 1'b1;
                m_address = c_address;
                c_resp    = m_resp;
                c_rdata   = m_rdata;
                if (m_resp) state_d = StIdle;
            end
            StMemWrite: begin
                m_write   = 1'b1;
                m_address = addr_q;
                m_wdata   = data_q;
                if (m_resp) begin
                    valid_d = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Keep the bus quiet while reset is held, even mid-transfer.
        if (rst) begin
            c_resp    = 1'b0;
            m_read    = 1'b0;
            m_write   = 1'b0;
            m_address = '0;
            m_wdata   = '0;
        end
    end

endmodule

// File: tb/tb_eviction_write_buffer.sv
// Directed, table-driven bench for eviction_write_buffer at the default line size.
module tb_eviction_write_buffer;

    localparam int unsigned W = 256;

    logic           clk;
    logic           rst;
    logic [31:0]    c_address;
    logic [W-1:0]   c_wdata;
    logic           c_read;
    logic           c_write;
    logic [W-1:0]   c_rdata;
    logic           c_resp;
    logic [31:0]    m_address;
    logic [W-1:0]   m_wdata;
    logic           m_read;
    logic           m_write;
    logic [W-1:0]   m_rdata;
    logic           m_resp;

    eviction_write_buffer #(.s_offset(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .c_address (c_address),
        .c_wdata   (c_wdata),
        .c_read    (c_read),
        .c_write   (c_write),
        .c_rdata   (c_rdata),
        .c_resp    (c_resp),
        .m_address (m_address),
        .m_wdata   (m_wdata),
        .m_read    (m_read),
        .m_write   (m_write),
        .m_rdata   (m_rdata),
        .m_resp    (m_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        int          wsel;
        logic        mresp;
        logic        e_resp;
        logic        e_mrd;
        logic        e_mwr;
        logic [31:0] e_maddr;
        int          e_wsel;
        int          e_rsel;   // -1: c_rdata not checked
    } vec_t;

    logic [W-1:0] lines [5];   // 0 zero, 1 L1, 2 L2, 3 L3, 4 arbiter read data
    vec_t         vecs [$];
    int           total;
    int           bad;

    function automatic vec_t v(int r, int rd, int wr, logic [31:0] a, int ws, int mr,
                               int er, int emr, int emw, logic [31:0] ema, int ews, int ers);
        vec_t t;
        t.rst = (r != 0);   t.rd = (rd != 0);   t.wr = (wr != 0);
        t.addr = a;         t.wsel = ws;        t.mresp = (mr != 0);
        t.e_resp = (er != 0); t.e_mrd = (emr != 0); t.e_mwr = (emw != 0);
        t.e_maddr = ema;    t.e_wsel = ews;     t.e_rsel = ers;
        return t;
    endfunction

    task automatic chk(input string name, input int idx, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step=%0d got=%h want=%h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic rd, input logic wr, input logic [31:0] a,
                         input logic [W-1:0] wd, input logic mr);
        rst = r; c_read = rd; c_write = wr; c_address = a; c_wdata = wd; m_resp = mr;
    endtask

    localparam logic [31:0] A = 32'h0000_1040;
    localparam logic [31:0] B = 32'h0000_1050;
    localparam logic [31:0] C = 32'h0000_2000;
    localparam logic [31:0] D = 32'h0000_3000;

    initial begin
        int found;
        int drains;
        total = 0;
        bad   = 0;
        lines[0] = '0;
        lines[1] = {8{32'h1111_0001}};
        lines[2] = {8{32'h2222_0002}};
        lines[3] = {8{32'h3333_0003}};
        lines[4] = {8{32'h4444_0004}};
        m_rdata  = lines[4];
        drive(1'b1, 1'b0, 1'b0, 32'h0, lines[0], 1'b0);

        //            rst rd wr addr ws mr | resp mrd mwr maddr mws rsel
        vecs.push_back(v(1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0));   // reset state
        vecs.push_back(v(1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, 0, 1, A, 1, 0,   0, 0, 0, 0, 0, 0));   // write L1 accepted
        vecs.push_back(v(0, 0, 1, A, 1, 0,   1, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0));   // idle -> drain
        vecs.push_back(v(0, 0, 0, 0, 0, 0,   0, 0, 1, A, 1, -1));
        vecs.push_back(v(0, 0, 0, 0, 0, 1,   0, 0, 1, A, 1, -1));
        vecs.push_back(v(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0));   // valid cleared
        vecs.push_back(v(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, 0, 1, A, 1, 0,   0, 0, 0, 0, 0, 0));   // rebuffer L1
        vecs.push_back(v(0, 0, 1, A, 1, 0,   1, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, 1, 0, B, 0, 0,   0, 0, 0, 0, 0, 0));   // read hit
        vecs.push_back(v(0, 1, 0, B, 0, 0,   1, 0, 0, 0, 0, 1));
        vecs.push_back(v(0, 1, 0, C, 0, 0,   0, 0, 0, 0, 0, 1));   // read miss bypass
        vecs.push_back(v(0, 1, 0, C, 0, 0,   0, 1, 0, C, 0, 4));
        vecs.push_back(v(0, 1, 0, C, 0, 1,   1, 1, 0, C, 0, 4));
        vecs.push_back(v(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 1));   // drain afterwards
        vecs.push_back(v(0, 0, 0, 0, 0, 0,   0, 0, 1, A, 1, -1));
        vecs.push_back(v(0, 0, 0, 0, 0, 1,   0, 0, 1, A, 1, -1));
        vecs.push_back(v(0, 0, 1, A, 1, 0,   0, 0, 0, 0, 0, 1));   // rebuffer L1
        vecs.push_back(v(0, 0, 1, A, 1, 0,   1, 0, 0, 0, 0, 1));
        vecs.push_back(v(0, 0, 1, D, 2, 0,   0, 0, 0, 0, 0, 1));   // conflicting write
        vecs.push_back(v(0, 0, 1, D, 2, 0,   0, 0, 1, A, 1, -1));
        vecs.push_back(v(0, 0, 1, D, 2, 1,   0, 0, 1, A, 1, -1));
        vecs.push_back(v(0, 0, 1, D, 2, 0,   0, 0, 0, 0, 0, 1));
        vecs.push_back(v(0, 0, 1, D, 2, 0,   1, 0, 0, 0, 0, 1));
        vecs.push_back(v(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 1));   // buffer holds D/L2
        vecs.push_back(v(0, 0, 0, 0, 0, 0,   0, 0, 1, D, 2, -1));
        vecs.push_back(v(0, 0, 0, 0, 0, 1,   0, 0, 1, D, 2, -1));
        vecs.push_back(v(0, 0, 1, A, 1, 0,   0, 0, 0, 0, 0, 1));   // coalesce L1 then L3
        vecs.push_back(v(0, 0, 1, A, 1, 0,   1, 0, 0, 0, 0, 1));
        vecs.push_back(v(0, 0, 1, A, 3, 0,   0, 0, 0, 0, 0, 1));
        vecs.push_back(v(0, 0, 1, A, 3, 0,   1, 0, 0, 0, 0, 1));
        vecs.push_back(v(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 1));
        vecs.push_back(v(0, 0, 0, 0, 0, 0,   0, 0, 1, A, 3, -1));
        vecs.push_back(v(0, 0, 0, 0, 0, 1,   0, 0, 1, A, 3, -1));
        vecs.push_back(v(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 1));   // single drain only
        vecs.push_back(v(0, 1, 1, A, 1, 0,   0, 0, 0, 0, 0, 1));   // write beats read
        vecs.push_back(v(0, 1, 1, A, 1, 0,   1, 0, 0, 0, 0, 1));

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].rd, vecs[i].wr, vecs[i].addr,
                  lines[vecs[i].wsel], vecs[i].mresp);
            #1;
            chk("c_resp", i, W'(c_resp), W'(vecs[i].e_resp));
            chk("m_read", i, W'(m_read), W'(vecs[i].e_mrd));
            chk("m_write", i, W'(m_write), W'(vecs[i].e_mwr));
            chk("m_address", i, W'(m_address), W'(vecs[i].e_maddr));
            chk("m_wdata", i, m_wdata, lines[vecs[i].e_wsel]);
            if (vecs[i].e_rsel >= 0) chk("c_rdata", i, c_rdata, lines[vecs[i].e_rsel]);
        end

        // Reset mid-drain: buffer holds A/L1, let it start draining then reset.
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 32'h0, lines[0], 1'b0);
        found = 0;
        for (int k = 0; k < 4 && found == 0; k++) begin
            @(negedge clk);
            #1;
            if (m_write) found = 1;
        end
        chk("drain_start", 1000, W'(found), W'(1));
        chk("drain_addr", 1001, W'(m_address), W'(A));
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 32'h0, lines[0], 1'b0);
        #1;
        chk("rst_hold_m_write", 1002, W'(m_write), W'(0));
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 32'h0, lines[0], 1'b0);
        #1;
        chk("post_rst_m_write", 1003, W'(m_write), W'(0));
        chk("post_rst_m_address", 1004, W'(m_address), W'(0));
        chk("post_rst_m_wdata", 1005, m_wdata, lines[0]);
        chk("post_rst_c_rdata", 1006, c_rdata, lines[0]);
        chk("post_rst_c_resp", 1007, W'(c_resp), W'(0));
        drains = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            #1;
            if (m_write || m_read) drains++;
        end
        chk("no_drain_after_rst", 1008, W'(drains), W'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
